// File: rtl/noc_local_iface_if.sv
// rtl/noc_local_iface_if.sv - core/router signal bundle for the NoC local interface
interface noc_local_iface_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_dest;
    logic [7:0]  tx_payload;
    logic [15:0] net_data_o;
    logic        net_enable_o;
    logic        net_credit_i;
    logic [15:0] net_data_i;
    logic        net_enable_i;
    logic        net_credit_o;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        credit_err;
    logic        rx_overflow;

    modport slave (
        input  tx_valid, tx_dest, tx_payload, net_credit_i, net_data_i, net_enable_i, rx_ready,
        output tx_ready, net_data_o, net_enable_o, net_credit_o, rx_valid, rx_data,
               credit_err, rx_overflow
    );

    modport master (
        output tx_valid, tx_dest, tx_payload, net_credit_i, net_data_i, net_enable_i, rx_ready,
        input  tx_ready, net_data_o, net_enable_o, net_credit_o, rx_valid, rx_data,
               credit_err, rx_overflow
    );
endinterface

// File: rtl/noc_local_iface.sv
// rtl/noc_local_iface.sv - credit-based TX path and RX FIFO between a core and its router local port
module noc_local_iface #(
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    noc_local_iface_if.slave  bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] CREDITS_C = CW'(CREDITS);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(RX_DEPTH);

    logic [CW-1:0] credit_cnt;
    logic          tx_ready_w;
    logic          tx_hs;
    logic          net_enable_q;
    logic [15:0]   net_data_q;
    logic          credit_err_q;

    assign tx_ready_w = (credit_cnt != '0);
    assign tx_hs      = bus.tx_valid && tx_ready_w;

    // A credit arriving with a handshake cancels out, so only a lone credit can overflow the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt   <= CREDITS_C;
            net_enable_q <= 1'b0;
            net_data_q   <= '0;
            credit_err_q <= 1'b0;
        end else begin
            net_enable_q <= tx_hs;
            if (tx_hs) begin
                net_data_q <= {bus.tx_payload, bus.tx_dest};
            end
            if (tx_hs && !bus.net_credit_i) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (!tx_hs && bus.net_credit_i) begin
                if (credit_cnt == CREDITS_C) begin
                    credit_err_q <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.tx_ready     = tx_ready_w;
    assign bus.net_enable_o = net_enable_q;
    assign bus.net_data_o   = net_data_q;
    assign bus.credit_err   = credit_err_q;

    logic [15:0]   rx_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          rx_valid_w;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_wr;
    logic          net_credit_q;
    logic          rx_overflow_q;

    assign rx_valid_w = (count != '0);
    assign rx_pop     = rx_valid_w && bus.rx_ready;
    assign rx_full    = (count == DEPTH_C);
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign rx_wr      = bus.net_enable_i && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (!rst && rx_wr) begin
            rx_mem[wr_ptr] <= bus.net_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            net_credit_q  <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            if (rx_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (rx_wr && !rx_pop) begin
                count <= count + 1'b1;
            end else if (!rx_wr && rx_pop) begin
                count <= count - 1'b1;
            end
            net_credit_q <= rx_pop;
            if (bus.net_enable_i && !rx_wr) begin
                rx_overflow_q <= 1'b1;
            end
        end
    end

    assign bus.rx_valid     = rx_valid_w;
    assign bus.rx_data      = rx_mem[rd_ptr];
    assign bus.net_credit_o = net_credit_q;
    assign bus.rx_overflow  = rx_overflow_q;
endmodule

// File: tb/tb_noc_local_iface.sv
// tb/tb_noc_local_iface.sv - scoreboard bench for noc_local_iface
module tb_noc_local_iface;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cred_pulses = 0;
    int   c0;
    logic pop_prev = 1'b0;
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] rxv [8];

    noc_local_iface_if bus();

    noc_local_iface #(.CREDITS(4), .RX_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.net_enable_o === 1'b1) begin
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%0h expected=none", bus.net_data_o);
            end else begin
                check("tx_flit", bus.net_data_o, tx_q.pop_front());
            end
        end
        if (!rst && bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            if (rx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected actual=%0h expected=none", bus.rx_data);
            end else begin
                check("rx_flit", bus.rx_data, rx_q.pop_front());
            end
        end
        if (bus.net_credit_o === 1'b1) cred_pulses++;
        if (pop_prev || bus.net_credit_o === 1'b1) check("net_credit_o", bus.net_credit_o, pop_prev);
        pop_prev = !rst && bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rxv[0] = 16'h1A1A; rxv[1] = 16'h2B2B; rxv[2] = 16'h3C3C; rxv[3] = 16'h4D4D;
        rxv[4] = 16'h5E5E; rxv[5] = 16'h6F6F; rxv[6] = 16'h7070; rxv[7] = 16'h8181;
        // reset with every input active: must be ignored
        bus.tx_valid = 1; bus.tx_dest = 8'hFF; bus.tx_payload = 8'hFF; bus.net_credit_i = 1;
        bus.net_data_i = 16'hFFFF; bus.net_enable_i = 1; bus.rx_ready = 1;
        tick; tick;
        rst = 0; bus.tx_valid = 0; bus.net_credit_i = 0; bus.net_enable_i = 0; bus.rx_ready = 0;
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_net_enable_o", bus.net_enable_o, 0);
        check("rst_net_data_o", bus.net_data_o, 0);
        check("rst_net_credit_o", bus.net_credit_o, 0);
        check("rst_credit_err", bus.credit_err, 0);
        check("rst_rx_overflow", bus.rx_overflow, 0);
        check("rst_rx_valid", bus.rx_valid, 0);

        // six offers with four credits
        bus.tx_dest = 8'h21;
        for (int i = 1; i <= 6; i++) begin
            bus.tx_valid = 1; bus.tx_payload = 8'(i);
            if (i <= 4) tx_q.push_back({8'(i), 8'h21});
            tick;
        end
        bus.tx_valid = 0;
        check("tx_ready_drained", bus.tx_ready, 0);
        tick;
        check("tx_ready_drained2", bus.tx_ready, 0);

        // single credit at zero while offering
        bus.tx_valid = 1; bus.tx_payload = 8'h07; bus.net_credit_i = 1;
        tick;
        bus.net_credit_i = 0;
        check("tx_ready_after_credit", bus.tx_ready, 1);
        tx_q.push_back(16'h0721);
        tick;
        check("tx_ready_one_shot", bus.tx_ready, 0);
        tick;
        bus.tx_valid = 0;

        // counter 2, handshake plus credit together
        bus.net_credit_i = 1; tick; tick;
        bus.tx_valid = 1; bus.tx_payload = 8'h08;
        tx_q.push_back(16'h0821);
        tick;
        bus.tx_valid = 0; bus.net_credit_i = 0;
        check("simul_credit_err", bus.credit_err, 0);
        check("simul_tx_ready", bus.tx_ready, 1);
        bus.net_credit_i = 1; tick; tick;
        bus.net_credit_i = 0;
        check("credit_err_at_max", bus.credit_err, 0);

        // credit while full
        bus.net_credit_i = 1; tick;
        bus.net_credit_i = 0;
        check("credit_err_set", bus.credit_err, 1);
        tick; tick;
        check("credit_err_sticky", bus.credit_err, 1);
        for (int i = 9; i <= 13; i++) begin
            bus.tx_valid = 1; bus.tx_payload = 8'(i);
            if (i <= 12) tx_q.push_back({8'(i), 8'h21});
            tick;
        end
        bus.tx_valid = 0;
        check("tx_ready_after_four", bus.tx_ready, 0);
        check("credit_err_still", bus.credit_err, 1);

        // RX fill past depth, then drain
        bus.rx_ready = 0;
        for (int i = 0; i < 5; i++) begin
            bus.net_enable_i = 1; bus.net_data_i = rxv[i];
            if (i < 4) rx_q.push_back(rxv[i]);
            tick;
            if (i == 0) begin
                check("rx_latency_valid", bus.rx_valid, 1);
                check("rx_latency_data", bus.rx_data, rxv[0]);
            end
            if (i == 3) check("rx_overflow_full", bus.rx_overflow, 0);
        end
        bus.net_enable_i = 0;
        check("rx_overflow_set", bus.rx_overflow, 1);
        check("rx_head", bus.rx_data, rxv[0]);
        tick; tick;
        check("rx_head_stable", bus.rx_data, rxv[0]);
        c0 = cred_pulses;
        bus.rx_ready = 1;
        repeat (6) tick;
        bus.rx_ready = 0;
        check("rx_credit_pulses", cred_pulses - c0, 4);
        check("rx_drained", bus.rx_valid, 0);

        // full FIFO with write and pop together
        rst = 1; tick; rst = 0;
        check("rst2_rx_overflow", bus.rx_overflow, 0);
        check("rst2_credit_err", bus.credit_err, 0);
        check("rst2_tx_ready", bus.tx_ready, 1);
        for (int i = 0; i < 4; i++) begin
            bus.net_enable_i = 1; bus.net_data_i = rxv[i + 2];
            rx_q.push_back(rxv[i + 2]);
            tick;
        end
        bus.net_data_i = rxv[6]; bus.rx_ready = 1;
        rx_q.push_back(rxv[6]);
        tick;
        bus.rx_ready = 0;
        check("full_pass_overflow", bus.rx_overflow, 0);
        bus.net_data_i = rxv[7];
        tick;
        bus.net_enable_i = 0;
        check("full_still_full", bus.rx_overflow, 1);
        bus.rx_ready = 1;
        repeat (6) tick;
        bus.rx_ready = 0;
        check("full_drained", bus.rx_valid, 0);

        // reset with flits in flight
        for (int i = 0; i < 2; i++) begin
            bus.net_enable_i = 1; bus.net_data_i = 16'hDEAD + 16'(i);
            tick;
        end
        bus.net_enable_i = 0;
        c0 = cred_pulses;
        rst = 1; bus.rx_ready = 1; bus.net_credit_i = 1;
        tick; tick;
        rst = 0; bus.rx_ready = 0; bus.net_credit_i = 0;
        check("midrst_rx_valid", bus.rx_valid, 0);
        check("midrst_net_credit_o", bus.net_credit_o, 0);
        check("midrst_tx_ready", bus.tx_ready, 1);
        tick; tick;
        check("midrst_no_pulse", cred_pulses - c0, 0);

        check("tx_q_empty", tx_q.size(), 0);
        check("rx_q_empty", rx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noc_local_iface.md
NOC_LOCAL_IFACE -- requirements
Module: noc_local_iface

Interface
- REQ-001: Parameter CREDITS, default 4: initial and maximum TX credit count, equal to the router local input buffer depth.
- REQ-002: Parameter RX_DEPTH, default 4, power of 2 and at least 2: RX FIFO depth in flits.
- REQ-003: Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
- REQ-004: Port rst, input, 1: reset, synchronous and active-high.
- REQ-005: Port tx_valid, input, 1: the core offers a flit.
- REQ-006: Port tx_ready, output, 1: the block can accept the offered flit.
- REQ-007: Port tx_dest, input, 8: destination, with X in [7:4] and Y in [3:0].
- REQ-008: Port tx_payload, input, 8: flit payload.
- REQ-009: Port net_data_o, output, 16: flit to the router local input, formatted {payload[15:8], dest[7:0]}.
- REQ-010: Port net_enable_o, output, 1: net_data_o is valid this cycle.
- REQ-011: Port net_credit_i, input, 1: one-cycle pulse; the router freed one local input slot.
- REQ-012: Port net_data_i, input, 16: flit from the router local output.
- REQ-013: Port net_enable_i, input, 1: net_data_i is valid this cycle.
- REQ-014: Port net_credit_o, output, 1: one-cycle pulse returning one RX slot to the router.
- REQ-015: Port rx_valid, output, 1: rx_data holds the RX FIFO head.
- REQ-016: Port rx_ready, input, 1: the core accepts rx_data.
- REQ-017: Port rx_data, output, 16: RX FIFO head flit, passed through unmodified.
- REQ-018: Port credit_err, output, 1: sticky flag, set when a credit arrives while the counter is already at CREDITS.
- REQ-019: Port rx_overflow, output, 1: sticky flag, set when a flit is dropped because the RX FIFO is full.

Function
- REQ-020: The TX credit counter SHALL be $clog2(CREDITS+1) bits wide.
- REQ-021: tx_ready SHALL equal (credit counter != 0), decoded from registered state.
- REQ-022: A TX handshake SHALL occur on a cycle where tx_valid and tx_ready are both 1.
- REQ-023: On a TX handshake, net_enable_o SHALL be 1 on the next cycle and net_data_o SHALL be {tx_payload, tx_dest}, both registered (latency 1).
- REQ-024: net_enable_o SHALL be 0 on every cycle that does not follow a TX handshake.
- REQ-025: net_data_o SHALL hold its last value when net_enable_o is 0.
- REQ-026: Credit counter update per cycle:
  - handshake only: decrement by 1;
  - net_credit_i only: increment by 1;
  - both together: unchanged.
- REQ-027: A net_credit_i with no handshake while the counter equals CREDITS SHALL leave the counter unchanged and set credit_err.
- REQ-028: At counter 0, tx_ready SHALL be 0 and tx_valid SHALL be ignored; a credit on that cycle SHALL raise tx_ready on the next cycle.
- REQ-029: The TX path SHALL sustain 1 flit per cycle while credits remain.
- REQ-030: The RX FIFO SHALL be circular, using log2(RX_DEPTH)-bit read and write pointers plus a count of log2(RX_DEPTH)+1 bits.
- REQ-031: rx_valid SHALL equal (count != 0).
- REQ-032: A pop SHALL occur when rx_valid and rx_ready are both 1.
- REQ-033: A write SHALL occur when net_enable_i is 1 and either count < RX_DEPTH or a pop occurs the same cycle.
- REQ-034: When net_enable_i is 1, count equals RX_DEPTH and no pop occurs, the flit SHALL be dropped, rx_overflow set, and pointers and count left unchanged.
- REQ-035: A simultaneous write and pop SHALL leave count unchanged and advance both pointers.
- REQ-036: Pointers SHALL wrap from RX_DEPTH-1 to 0.
- REQ-037: The RX FIFO SHALL be first-in first-out, and rx_data SHALL be stable while rx_valid is 1 and rx_ready is 0.
- REQ-038: net_credit_o SHALL pulse 1 for exactly one cycle, on the cycle after each pop (registered); back-to-back pops SHALL produce back-to-back pulses.
- REQ-039: A flit written into an empty FIFO SHALL appear at rx_valid one cycle after its net_enable_i cycle.

Reset
- REQ-040: While rst is 1 at a clock edge, the block SHALL set: credit counter = CREDITS; RX pointers and count = 0; net_enable_o = 0; net_data_o = 0; net_credit_o = 0; credit_err = 0; rx_overflow = 0.
- REQ-041: While rst is 1, net_credit_i, net_enable_i, tx_valid and rx_ready SHALL be ignored.
- REQ-042: A reset asserted mid-traffic SHALL discard in-flight RX contents and restore credits without emitting any net_credit_o pulse.
- REQ-043: tx_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
- REQ-044: With CREDITS=4, hold tx_valid=1 for 6 cycles with dest 8'h21 and payloads 1..6, and no net_credit_i -> exactly 4 net_enable_o pulses with data 16'h0121 to 16'h0421; tx_ready is 0 thereafter.
- REQ-045: From counter 0, pulse net_credit_i once while tx_valid=1 -> tx_ready=1 for one cycle and one flit is sent.
- REQ-046: From counter 2, assert a handshake and net_credit_i on the same cycle -> counter stays 2, one flit is sent, credit_err=0.
- REQ-047: With the counter at 4, pulse net_credit_i -> credit_err=1 and stays 1 until reset; counter stays 4.
- REQ-048: With RX_DEPTH=4 and rx_ready=0, write flits A,B,C,D,E -> E dropped and rx_overflow=1; then set rx_ready=1 -> A,B,C,D in order, with 4 net_credit_o pulses each one cycle after its pop.
- REQ-049: With the RX FIFO full, net_enable_i=1 and rx_ready=1 on the same cycle -> the new flit is accepted, count stays 4, rx_overflow stays 0.
